// File: rtl/bcd_to_binary_if.sv
// Operand/result bundle for the sequential BCD-to-binary converter.
// A transfer happens on a clk edge where valid and ready are both 1; valid holds until that edge.
interface bcd_to_binary_if #(
  parameter int DIGITS = 5,
  parameter int BIN_W  = 16
);
  logic                  in_valid;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      bin_out;
  logic                  digit_err;
  logic                  ovf;

  modport master (
    output in_valid, bcd_in, out_ready,
    input  in_ready, out_valid, bin_out, digit_err, ovf
  );

  modport slave (
    input  in_valid, bcd_in, out_ready,
    output in_ready, out_valid, bin_out, digit_err, ovf
  );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter: one reverse double-dabble step per cycle,
// BIN_W cycles per operand, results held until the consumer accepts them.
module bcd_to_binary_seq #(
  parameter int DIGITS = 5,
  parameter int BIN_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  bcd_to_binary_if.slave  bus,
  output logic [1:0]      state_dbg
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [BCD_W-1:0] bcd_reg;
  logic [BCD_W-1:0] bcd_next;
  logic [BIN_W-1:0] acc;
  logic [BIN_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic             err_reg;
  logic             ovf_reg;
  logic             in_err;

  // One step: shift {bcd_reg, acc} right, then pull each digit that reached 8+ back by 3.
  always_comb begin
    bcd_next = {1'b0, bcd_reg[BCD_W-1:1]};
    acc_next = {bcd_reg[0], acc[BIN_W-1:1]};
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_next[4*d+3]) begin
        bcd_next[4*d +: 4] = bcd_next[4*d +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    in_err = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bus.bcd_in[4*d +: 4] > 4'd9) begin
        in_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      bcd_reg <= '0;
      acc     <= '0;
      cnt     <= '0;
      err_reg <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            bcd_reg <= bus.bcd_in;
            acc     <= '0;
            cnt     <= '0;
            err_reg <= in_err;
            ovf_reg <= 1'b0;
            state   <= S_CONV;
          end
        end
        S_CONV: begin
          bcd_reg <= bcd_next;
          acc     <= acc_next;
          // The counter parks on the last step value rather than wrapping.
          if (cnt == LAST_STEP) begin
            ovf_reg <= |bcd_next;
            state   <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.bin_out   = err_reg ? '0 : acc;
  assign bus.digit_err = err_reg;
  assign bus.ovf       = ovf_reg & ~err_reg;
  assign state_dbg     = state;
endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed bench for bcd_to_binary_seq: reset, nominal, bounds, invalid digits,
// backpressure, back-to-back operands and asynchronous reset mid-conversion.
module tb_bcd_to_binary_seq;
  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  int         pass_cnt;
  int         chk_cnt;

  bcd_to_binary_if #(.DIGITS(5), .BIN_W(16)) bus ();

  bcd_to_binary_seq #(.DIGITS(5), .BIN_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfer one operand, scramble bcd_in afterwards, and count edges until out_valid.
  task automatic send_op(input logic [19:0] v, output int lat);
    int w;
    lat = -1;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    bus.in_valid = 1'b1;
    bus.bcd_in   = v;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.bcd_in   = 20'($urandom_range(0, 20'hFFFFF));
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic accept_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.in_valid  = 1'b1;
    bus.bcd_in    = 20'h12345;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); else pass_cnt++;
    chk_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); else pass_cnt++;
    chk_cnt++; if (bus.bin_out !== 16'h0) $display("FAIL reset_bin_out got=%h exp=0000", bus.bin_out); else pass_cnt++;
    chk_cnt++; if (bus.digit_err !== 1'b0 || bus.ovf !== 1'b0) $display("FAIL reset_flags got=%b%b exp=00", bus.digit_err, bus.ovf); else pass_cnt++;
    chk_cnt++; if (state_dbg !== 2'd0) $display("FAIL reset_state got=%0d exp=0", state_dbg); else pass_cnt++;
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_nominal();
    int lat;
    send_op(20'h12345, lat);
    chk_cnt++; if (lat !== 16) $display("FAIL nominal_latency got=%0d exp=16", lat); else pass_cnt++;
    chk_cnt++; if (bus.bin_out !== 16'h3039) $display("FAIL nominal_bin got=%h exp=3039", bus.bin_out); else pass_cnt++;
    chk_cnt++; if (bus.digit_err !== 1'b0 || bus.ovf !== 1'b0) $display("FAIL nominal_flags got=%b%b exp=00", bus.digit_err, bus.ovf); else pass_cnt++;
    chk_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL nominal_in_ready got=%b exp=0", bus.in_ready); else pass_cnt++;
    accept_result();
    chk_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL nominal_release got=%b%b exp=01", bus.out_valid, bus.in_ready); else pass_cnt++;
  endtask

  task automatic test_bounds();
    logic [19:0] ops [4];
    logic [15:0] exp_bin [4];
    logic        exp_ovf [4];
    int lat;
    ops[0] = 20'h00000; exp_bin[0] = 16'h0000; exp_ovf[0] = 1'b0;
    ops[1] = 20'h65535; exp_bin[1] = 16'hFFFF; exp_ovf[1] = 1'b0;
    ops[2] = 20'h65536; exp_bin[2] = 16'h0000; exp_ovf[2] = 1'b1;
    ops[3] = 20'h99999; exp_bin[3] = 16'h869F; exp_ovf[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_op(ops[k], lat);
      chk_cnt++; if (lat !== 16) $display("FAIL bounds_latency op=%h got=%0d exp=16", ops[k], lat); else pass_cnt++;
      chk_cnt++; if (bus.bin_out !== exp_bin[k]) $display("FAIL bounds_bin op=%h got=%h exp=%h", ops[k], bus.bin_out, exp_bin[k]); else pass_cnt++;
      chk_cnt++; if (bus.ovf !== exp_ovf[k]) $display("FAIL bounds_ovf op=%h got=%b exp=%b", ops[k], bus.ovf, exp_ovf[k]); else pass_cnt++;
      chk_cnt++; if (bus.digit_err !== 1'b0) $display("FAIL bounds_err op=%h got=%b exp=0", ops[k], bus.digit_err); else pass_cnt++;
      accept_result();
    end
  endtask

  task automatic test_invalid_digit();
    int lat;
    send_op(20'h1A345, lat);
    chk_cnt++; if (lat !== 16) $display("FAIL invalid_latency got=%0d exp=16", lat); else pass_cnt++;
    chk_cnt++; if (bus.digit_err !== 1'b1) $display("FAIL invalid_err got=%b exp=1", bus.digit_err); else pass_cnt++;
    chk_cnt++; if (bus.ovf !== 1'b0) $display("FAIL invalid_ovf got=%b exp=0", bus.ovf); else pass_cnt++;
    chk_cnt++; if (bus.bin_out !== 16'h0) $display("FAIL invalid_bin got=%h exp=0000", bus.bin_out); else pass_cnt++;
    accept_result();
    // Clean operand right after an error must come back with the flag cleared.
    send_op(20'h00999, lat);
    chk_cnt++; if (bus.digit_err !== 1'b0 || bus.bin_out !== 16'h03E7) $display("FAIL invalid_recover got=%b/%h exp=0/03e7", bus.digit_err, bus.bin_out); else pass_cnt++;
    accept_result();
  endtask

  task automatic test_backpressure();
    int lat;
    send_op(20'h00999, lat);
    chk_cnt++; if (lat !== 16) $display("FAIL bp_latency got=%0d exp=16", lat); else pass_cnt++;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bcd_in   = 20'h00123;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk_cnt++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.bin_out !== 16'h03E7 || bus.digit_err !== 1'b0 || bus.ovf !== 1'b0)
        $display("FAIL bp_hold cycle=%0d got=%b%b/%h/%b%b exp=10/03e7/00", c, bus.out_valid, bus.in_ready, bus.bin_out, bus.digit_err, bus.ovf);
      else pass_cnt++;
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL bp_release got=%b%b exp=01", bus.out_valid, bus.in_ready); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++; if (state_dbg !== 2'd0) $display("FAIL bp_ignored_state got=%0d exp=0", state_dbg); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;
    int lat;
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd10);
    send_op(20'h00001, lat);
    exp_v = exp_q.pop_front();
    chk_cnt++; if (lat !== 16 || bus.bin_out !== exp_v) $display("FAIL b2b_first got=%0d/%h exp=16/%h", lat, bus.bin_out, exp_v); else pass_cnt++;
    accept_result();
    send_op(20'h00010, lat);
    exp_v = exp_q.pop_front();
    chk_cnt++; if (lat !== 16 || bus.bin_out !== exp_v) $display("FAIL b2b_second got=%0d/%h exp=16/%h", lat, bus.bin_out, exp_v); else pass_cnt++;
    accept_result();
  endtask

  task automatic test_reset_mid_op();
    int lat;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.bcd_in   = 20'h99999;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    chk_cnt++; if (state_dbg !== 2'd1) $display("FAIL midrst_in_conv got=%0d exp=1", state_dbg); else pass_cnt++;
    reset = 1'b0;
    #1;
    chk_cnt++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL midrst_async got=%b%b exp=01", bus.out_valid, bus.in_ready); else pass_cnt++;
    chk_cnt++; if (bus.bin_out !== 16'h0 || bus.ovf !== 1'b0) $display("FAIL midrst_clear got=%h/%b exp=0000/0", bus.bin_out, bus.ovf); else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    send_op(20'h00042, lat);
    chk_cnt++; if (lat !== 16) $display("FAIL midrst_latency got=%0d exp=16", lat); else pass_cnt++;
    chk_cnt++; if (bus.bin_out !== 16'h002A || bus.ovf !== 1'b0 || bus.digit_err !== 1'b0) $display("FAIL midrst_result got=%h/%b%b exp=002a/00", bus.bin_out, bus.digit_err, bus.ovf); else pass_cnt++;
    accept_result();
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    reset = 1'b0;
    bus.in_valid  = 1'b0;
    bus.bcd_in    = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_nominal();
    test_bounds();
    test_invalid_digit();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/bcd_to_binary_seq.md
BCD_TO_BINARY_SEQ -- requirements
Module: bcd_to_binary_seq

Interface
REQ-001 Parameter DIGITS, default 5, is the number of packed BCD input digits, units digit in bits [3:0].
REQ-002 Parameter BIN_W, default 16, is the binary result width and the iteration count per conversion.
REQ-003 clk  input  1  clock; all state changes on the positive edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 clears all state immediately, independent of clk.
REQ-005 in_valid  input  1  request: bcd_in holds an operand.
REQ-006 bcd_in  input  4*DIGITS  packed BCD operand.
REQ-007 in_ready  output  1  block can accept an operand this cycle.
REQ-008 out_valid  output  1  result fields are valid.
REQ-009 out_ready  input  1  consumer accepts the result this cycle.
REQ-010 bin_out  output  BIN_W  binary value of the operand.
REQ-011 digit_err  output  1  at least one operand nibble exceeded 9.
REQ-012 ovf  output  1  operand value is 2^BIN_W or greater.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, CONV and DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in CONV and DONE, in_ready SHALL be 0.
REQ-015 Input transfer SHALL occur on a clk edge where in_valid=1 and in_ready=1; bcd_in is captured into a 4*DIGITS shift register, the BIN_W accumulator is cleared, the iteration counter is cleared, and the state moves to CONV.
REQ-016 At capture, digit_err SHALL be latched as the OR over all nibbles of (nibble > 9).
REQ-017 Each CONV cycle SHALL perform one reverse double-dabble step.
  - Shift the concatenation {bcd_reg, acc} right by one bit, with 0 entering the bcd_reg MSB.
  - Then subtract 3 from every 4-bit digit of bcd_reg whose shifted value is 8 or more.
REQ-018 Exactly BIN_W CONV steps SHALL be performed; the edge that performs step BIN_W also moves the state to DONE.
REQ-019 out_valid SHALL be 1 exactly when the state is DONE, first on the BIN_W-th edge after the input-transfer edge (latency BIN_W cycles).
REQ-020 On entry to DONE, ovf SHALL be set if any bcd_reg bit is nonzero after the final step.
REQ-021 bin_out SHALL equal acc when digit_err=0 and SHALL be forced to 0 when digit_err=1.
REQ-022 ovf SHALL be 0 whenever digit_err=1.
REQ-023 When ovf=1 and digit_err=0, bin_out SHALL equal the operand value modulo 2^BIN_W.
REQ-024 In DONE, bin_out, digit_err and ovf SHALL hold stable until output transfer (out_valid=1 and out_ready=1 at an edge), which returns the state to IDLE.
REQ-025 in_valid and bcd_in SHALL be ignored outside IDLE.
REQ-026 No pass-through: a new input is never accepted on the same edge as output transfer; the minimum spacing is BIN_W+2 cycles per operand.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 Changes on bcd_in after the input-transfer edge SHALL NOT affect the current result.
REQ-029 The iteration counter SHALL be ceil(log2(BIN_W+1)) bits wide and SHALL NOT wrap within a conversion.

Reset
REQ-030 While reset=0, the block SHALL hold:
  - state=IDLE, in_ready=1, out_valid=0;
  - bin_out=0, digit_err=0, ovf=0;
  - counter, bcd_reg and acc all at 0.
REQ-031 Assertion of reset during CONV or DONE SHALL abandon the operation with no output transfer.
REQ-032 After reset releases, the first input transfer SHALL be possible on the first clk edge.

Verification
REQ-033 Nominal: bcd_in=20'h12345 -> out_valid on the 16th edge after transfer, bin_out=16'h3039, digit_err=0, ovf=0.
REQ-034 Bounds:
  - 20'h00000 -> bin_out=0, ovf=0.
  - 20'h65535 -> bin_out=16'hFFFF, ovf=0.
  - 20'h65536 -> ovf=1, bin_out=16'h0000.
  - 20'h99999 -> ovf=1, bin_out=16'h869F.
REQ-035 Invalid digit: bcd_in=20'h1A345 -> digit_err=1, ovf=0, bin_out=0, latency still 16 cycles.
REQ-036 Backpressure and streaming:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, a second in_valid is ignored.
  - Then raise out_ready -> IDLE next edge.
  - Then send back-to-back operands 20'h00001 and 20'h00010 -> results 1 and 10, in order.
REQ-037 Reset mid-operation: drive reset=0 at CONV step 7 -> out_valid=0 and in_ready=1 immediately (asynchronous).
  - After release, 20'h00042 converts to 16'h002A with no residue from the aborted operand.
